// File: rtl/scan_seq_pkg.sv
// Shared definitions for the scan sequencer slice: FSM state encoding,
// channel code width and the default dwell counter width.
package scan_seq_pkg;

  // Sequencer states: waiting for start, or stepping through channel codes
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Width of the channel code driven into the 3-to-8 decoder
  localparam int CODE_W = 3;

  // Default width of the dwell input and the internal dwell counter
  localparam int DEFAULT_DWELL_W = 8;

endpackage

// File: rtl/scan_dwell_counter.sv
// Loadable down-counter that measures how long each channel code is held.
// Clear has priority over load, load has priority over decrement, and the
// count never wraps below zero.
module scan_dwell_counter
  import scan_seq_pkg::*;
#(
  parameter int DWELL_W = DEFAULT_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] loadValue_i,
  input  logic               enable_i,
  output logic [DWELL_W-1:0] count_o,
  output logic               zero_o
);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;

  // Choose the next count from clear, load or decrement requests
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = loadValue_i;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - DWELL_W'(1);
    end
  end

  // Hold the count; reset returns it to zero immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a channel code 0..LAST_CH into the 3-to-8 decoder,
// holding each code for a latched dwell time, in one-shot or wrapping mode.
// Optional feature macro: SCAN_SEQUENCER_PAUSE_EN adds a pause input that
// freezes an active scan without dropping code_valid/busy.
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int DWELL_W = DEFAULT_DWELL_W,
  parameter int LAST_CH = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_SEQUENCER_PAUSE_EN
  input  logic               pause,
`endif
  output logic [CODE_W-1:0]  code,
  output logic               code_valid,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  localparam logic [CODE_W-1:0]  LAST_CODE = CODE_W'(LAST_CH);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  scan_state_e        state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               codeValid_q, codeValid_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic               oneshot_q, oneshot_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic               cntClear;
  logic               cntLoad;
  logic [DWELL_W-1:0] cntLoadValue;
  logic               cntEnable;
  logic [DWELL_W-1:0] cntValue;
  logic               cntZero;
  logic [DWELL_W-1:0] effDwell;
  logic               pauseActive;

  // A requested dwell of zero still shows each code for one cycle
  assign effDwell = (dwell == '0) ? DWELL_ONE : dwell;

`ifdef SCAN_SEQUENCER_PAUSE_EN
  assign pauseActive = pause;
`else
  assign pauseActive = 1'b0;
`endif

  scan_dwell_counter #(
    .DWELL_W(DWELL_W)
  ) u_dwellCounter (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (cntClear),
    .load_i     (cntLoad),
    .loadValue_i(cntLoadValue),
    .enable_i   (cntEnable),
    .count_o    (cntValue),
    .zero_o     (cntZero)
  );

  // Next-state, next-output and counter control for the IDLE/SCAN machine
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    codeValid_d  = codeValid_q;
    busy_d       = busy_q;
    wrap_d       = 1'b0;
    done_d       = 1'b0;
    oneshot_d    = oneshot_q;
    dwell_d      = dwell_q;
    cntClear     = 1'b0;
    cntLoad      = 1'b0;
    cntLoadValue = dwell_q - DWELL_ONE;
    cntEnable    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d      = ST_SCAN;
          code_d       = '0;
          codeValid_d  = 1'b1;
          busy_d       = 1'b1;
          oneshot_d    = oneshot;
          dwell_d      = effDwell;
          cntLoad      = 1'b1;
          cntLoadValue = effDwell - DWELL_ONE;
        end
      end

      ST_SCAN: begin
        if (stop) begin
          state_d     = ST_IDLE;
          code_d      = '0;
          codeValid_d = 1'b0;
          busy_d      = 1'b0;
          cntClear    = 1'b1;
        end else if (pauseActive) begin
          state_d = ST_SCAN;
        end else if (!cntZero) begin
          cntEnable = 1'b1;
        end else if (code_q != LAST_CODE) begin
          code_d  = code_q + CODE_W'(1);
          cntLoad = 1'b1;
        end else if (!oneshot_q) begin
          code_d  = '0;
          cntLoad = 1'b1;
          wrap_d  = 1'b1;
        end else begin
          state_d     = ST_IDLE;
          code_d      = '0;
          codeValid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          cntClear    = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register state, outputs and latched scan settings
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      codeValid_q <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      oneshot_q   <= 1'b0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      codeValid_q <= codeValid_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
      oneshot_q   <= oneshot_d;
      dwell_q     <= dwell_d;
    end
  end

  assign code       = code_q;
  assign code_valid = codeValid_q;
  assign busy       = busy_q;
  assign wrap       = wrap_q;
  assign done       = done_q;

endmodule
